// File: rtl/my_logic_alu_pkg.sv
// Shared types and helpers for the multi-lane logic/arithmetic unit.
// Op encoding is fixed; codes 6 and 7 are reserved and flagged as errors.
package my_logic_alu_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_ADD  = 3'd4,
      OP_SUB  = 3'd5
   } op_t;

   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      return (op <= OP_W'(OP_SUB));
   endfunction

endpackage

// File: rtl/my_logic_alu_lane.sv
// One combinational lane: WIDTH-bit operands in, WIDTH+1-bit result out.
// The extra MSB carries the add carry-out or the subtract borrow.
module my_logic_alu_lane
   import my_logic_alu_pkg::*;
#(
   parameter int INPUT_WIDTH = 1
) (
   input  logic [OP_W-1:0]        op,
   input  logic [INPUT_WIDTH-1:0] a,
   input  logic [INPUT_WIDTH-1:0] b,
   output logic [INPUT_WIDTH:0]   r
);

   always_comb begin
      r = '0;
      case (op)
         OP_AND:  r = {1'b0, a & b};
         OP_OR:   r = {1'b0, a | b};
         OP_XOR:  r = {1'b0, a ^ b};
         OP_NAND: r = {1'b0, ~(a & b)};
         OP_ADD:  r = {1'b0, a} + {1'b0, b};
         // Wraps modulo 2^(W+1), so the MSB is set exactly when a < b.
         OP_SUB:  r = {1'b0, a} - {1'b0, b};
         default: r = '0;
      endcase
   end

endmodule

// File: rtl/my_logic_alu.sv
// Two-stage valid/ready pipeline around NUM_CH parallel ALU lanes:
// S1 holds operands and op, S2 holds the computed result and error flag.
module my_logic_alu
   import my_logic_alu_pkg::*;
#(
   parameter int INPUT_WIDTH = 1,
   parameter int NUM_CH      = 1,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                                clock_in,
   input  logic                                reset_in,
   input  logic [OP_W-1:0]                     op_in,
   input  logic [NUM_CH*INPUT_WIDTH-1:0]       a_in,
   input  logic [NUM_CH*INPUT_WIDTH-1:0]       b_in,
   input  logic                                in_valid_in,
   output logic                                in_ready_out,
   output logic [NUM_CH*(INPUT_WIDTH+1)-1:0]   c_out,
   output logic                                err_out,
   output logic                                out_valid_out,
   input  logic                                out_ready_in,
   output logic [CNT_WIDTH-1:0]                count_out
);

   localparam int LW = INPUT_WIDTH + 1;

   typedef logic [NUM_CH-1:0][INPUT_WIDTH-1:0] opnd_t;
   typedef logic [NUM_CH-1:0][LW-1:0]          res_t;

   logic              s1_valid_q, s1_valid_d;
   logic [OP_W-1:0]   s1_op_q, s1_op_d;
   opnd_t             s1_a_q, s1_a_d;
   opnd_t             s1_b_q, s1_b_d;

   logic              out_valid_q, out_valid_d;
   res_t              c_q, c_d;
   logic              err_q, err_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   res_t              lane_r;
   logic              s1_adv, s2_adv;
   logic              in_xfer, out_xfer;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      my_logic_alu_lane #(
         .INPUT_WIDTH(INPUT_WIDTH)
      ) u_lane (
         .op (s1_op_q),
         .a  (s1_a_q[k]),
         .b  (s1_b_q[k]),
         .r  (lane_r[k])
      );
   end

   // Ready is derived only from pipeline state and the consumer's ready,
   // never from in_valid_in, so upstream sees no combinational loop.
   assign s2_adv       = !out_valid_q || out_ready_in;
   assign s1_adv       = s2_adv;
   assign in_ready_out = !s1_valid_q || s1_adv;
   assign in_xfer      = in_valid_in && in_ready_out;
   assign out_xfer     = out_valid_q && out_ready_in;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_op_d     = s1_op_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      out_valid_d = out_valid_q;
      c_d         = c_q;
      err_d       = err_q;
      cnt_d       = cnt_q;

      if (in_ready_out) begin
         s1_valid_d = in_valid_in;
      end
      if (in_xfer) begin
         s1_op_d = op_in;
         s1_a_d  = a_in;
         s1_b_d  = b_in;
      end

      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         c_d         = s1_valid_q ? lane_r : '0;
         err_d       = s1_valid_q && !is_legal_op(s1_op_q);
      end

      if (out_xfer) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= '0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         out_valid_q <= 1'b0;
         c_q         <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         out_valid_q <= out_valid_d;
         c_q         <= c_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign c_out         = c_q;
   assign err_out       = err_q;
   assign out_valid_out = out_valid_q;
   assign count_out     = cnt_q;

endmodule
